fiber_dram_wb_queue: RTL

Sits directly downstream of fiberBank's DRAM crossbar. Buffers evicted/written-back lines in a small FIFO and drains them to the DRAM port. Serves fill reads from fiberBank, forwarding data from a queued write when the address matches, otherwise issuing a DRAM read. Guarantees read-after-write correctness between pending writebacks and fills.

---
 rtl/fiber_dram_wb_queue_if.sv | 48 ++++
 rtl/fiber_dram_wb_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fiber_dram_wb_queue_if.sv
// Bundles the bank-side writeback/fill channels and the DRAM request/response
// channels of fiber_dram_wb_queue. The slave modport is the queue itself; the
// master modport is the environment (bank crossbar plus DRAM port).
interface fiber_dram_wb_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] i_wb_addr;
  logic [DATA_WIDTH-1:0] i_wb_data;
  logic                  i_wb_valid;
  logic                  o_wb_ready;
  logic [ADDR_WIDTH-1:0] i_fill_addr;
  logic                  i_fill_valid;
  logic                  o_fill_ready;
  logic [DATA_WIDTH-1:0] o_fill_data;
  logic                  o_fill_valid;
  logic                  i_fill_ready;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_we;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic [DATA_WIDTH-1:0] i_mem_rdata;
  logic                  i_mem_rvalid;
  logic                  o_mem_rready;

  modport slave (
    input  i_wb_addr, i_wb_data, i_wb_valid,
    output o_wb_ready,
    input  i_fill_addr, i_fill_valid,
    output o_fill_ready, o_fill_data, o_fill_valid,
    input  i_fill_ready,
    output o_mem_addr, o_mem_we, o_mem_wdata, o_mem_req_valid,
    input  i_mem_req_ready, i_mem_rdata, i_mem_rvalid,
    output o_mem_rready
  );

  modport master (
    output i_wb_addr, i_wb_data, i_wb_valid,
    input  o_wb_ready,
    output i_fill_addr, i_fill_valid,
    input  o_fill_ready, o_fill_data, o_fill_valid,
    output i_fill_ready,
    input  o_mem_addr, o_mem_we, o_mem_wdata, o_mem_req_valid,
    output i_mem_req_ready, i_mem_rdata, i_mem_rvalid,
    input  o_mem_rready
  );
endinterface

// File: rtl/fiber_dram_wb_queue.sv
// Writeback queue between fiberBank's DRAM crossbar and the DRAM port.
// Evicted lines are buffered in a small FIFO and drained as DRAM writes; fill
// reads are forwarded from the youngest queued write to the same address, or
// else issued as a DRAM read. One fill is outstanding at a time.
// Optional build macro FIBER_WBQ_COALESCE_EN: a writeback to an address that is
// already queued overwrites that entry in place (accepted even when full).
module fiber_dram_wb_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fiber_dram_wb_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  logic [ADDR_WIDTH-1:0] addr_q_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_q_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r, count_next_s;
  state_t                state_r;

  logic                  wb_ready_r, fill_ready_r, fill_valid_r;
  logic [DATA_WIDTH-1:0] fill_data_r, mem_wdata_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  mem_we_r, mem_req_valid_r, mem_rready_r;

  logic                  wb_ready_s, wb_fire_s, push_s, pop_s;
  logic                  coal_hit_s, coal_wr_s;
  logic [PW-1:0]         coal_idx_s;
  logic                  fill_hit_s;
  logic [DATA_WIDTH-1:0] fill_hit_data_s, head_data_s;

  // Search every live entry for the fill address; later (younger) matches win
  always_comb begin : fill_search
    logic m;
    m               = 1'b0;
    fill_hit_s      = 1'b0;
    fill_hit_data_s = '0;
    for (int a = 0; a < DEPTH; a++) begin
      m = (CW'(a) < count_r) && (addr_q_r[rd_ptr_r + PW'(a)] == bus.i_fill_addr);
      fill_hit_s      = fill_hit_s | m;
      fill_hit_data_s = m ? data_q_r[rd_ptr_r + PW'(a)] : fill_hit_data_s;
    end
  end

`ifdef FIBER_WBQ_COALESCE_EN
  // Find a queued entry the incoming writeback may overwrite; the head is
  // excluded while it is being presented to DRAM so its payload stays stable
  always_comb begin : coal_search
    logic m;
    m          = 1'b0;
    coal_hit_s = 1'b0;
    coal_idx_s = '0;
    for (int a = 0; a < DEPTH; a++) begin
      m = (CW'(a) < count_r) && (addr_q_r[rd_ptr_r + PW'(a)] == bus.i_wb_addr) &&
          !((a == 0) && (state_r == DRAIN));
      coal_hit_s = coal_hit_s | m;
      coal_idx_s = m ? (rd_ptr_r + PW'(a)) : coal_idx_s;
    end
  end
  assign wb_ready_s = wb_ready_r | coal_hit_s;
`else
  assign coal_hit_s = 1'b0;
  assign coal_idx_s = '0;
  assign wb_ready_s = wb_ready_r;
`endif

  assign wb_fire_s = bus.i_wb_valid & wb_ready_s;
  assign push_s    = wb_fire_s & ~coal_hit_s;
  assign coal_wr_s = wb_fire_s & coal_hit_s;
  assign pop_s     = (state_r == DRAIN) & mem_req_valid_r & bus.i_mem_req_ready;

  // A coalescing write to the head in the same cycle the drain starts must
  // reach DRAM, so forward it into the drain payload
  assign head_data_s = (coal_wr_s && (coal_idx_s == rd_ptr_r)) ? bus.i_wb_data
                                                               : data_q_r[rd_ptr_r];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Writeback FIFO storage, pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q_r[i] <= '0;
        data_q_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        addr_q_r[wr_ptr_r] <= bus.i_wb_addr;
        data_q_r[wr_ptr_r] <= bus.i_wb_data;
        wr_ptr_r           <= wr_ptr_r + PW'(1);
      end
      if (coal_wr_s) begin
        data_q_r[coal_idx_s] <= bus.i_wb_data;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Control FSM with registered bank- and DRAM-side outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r         <= IDLE;
      wb_ready_r      <= 1'b1;
      fill_ready_r    <= 1'b0;
      fill_valid_r    <= 1'b0;
      fill_data_r     <= '0;
      mem_addr_r      <= '0;
      mem_we_r        <= 1'b0;
      mem_wdata_r     <= '0;
      mem_req_valid_r <= 1'b0;
      mem_rready_r    <= 1'b0;
    end else begin
      wb_ready_r <= (count_next_s != FULL_COUNT);
      case (state_r)
        IDLE: begin
          if (count_r == FULL_COUNT) begin
            fill_ready_r    <= 1'b0;
            mem_req_valid_r <= 1'b1;
            mem_we_r        <= 1'b1;
            mem_addr_r      <= addr_q_r[rd_ptr_r];
            mem_wdata_r     <= head_data_s;
            state_r         <= DRAIN;
          end else if (bus.i_fill_valid && fill_ready_r) begin
            fill_ready_r <= 1'b0;
            if (fill_hit_s) begin
              fill_data_r  <= fill_hit_data_s;
              fill_valid_r <= 1'b1;
              state_r      <= RESP;
            end else begin
              mem_addr_r      <= bus.i_fill_addr;
              mem_we_r        <= 1'b0;
              mem_req_valid_r <= 1'b1;
              state_r         <= RD_REQ;
            end
          end else if (count_r != '0) begin
            fill_ready_r    <= 1'b0;
            mem_req_valid_r <= 1'b1;
            mem_we_r        <= 1'b1;
            mem_addr_r      <= addr_q_r[rd_ptr_r];
            mem_wdata_r     <= head_data_s;
            state_r         <= DRAIN;
          end else begin
            fill_ready_r <= (count_next_s != FULL_COUNT);
          end
        end
        DRAIN: begin
          if (bus.i_mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            mem_we_r        <= 1'b0;
            fill_ready_r    <= (count_next_s != FULL_COUNT);
            state_r         <= IDLE;
          end
        end
        RD_REQ: begin
          if (bus.i_mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            mem_rready_r    <= 1'b1;
            state_r         <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.i_mem_rvalid) begin
            fill_data_r  <= bus.i_mem_rdata;
            fill_valid_r <= 1'b1;
            mem_rready_r <= 1'b0;
            state_r      <= RESP;
          end
        end
        RESP: begin
          if (bus.i_fill_ready) begin
            fill_valid_r <= 1'b0;
            fill_ready_r <= (count_next_s != FULL_COUNT);
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r         <= IDLE;
          fill_ready_r    <= 1'b0;
          fill_valid_r    <= 1'b0;
          mem_req_valid_r <= 1'b0;
          mem_we_r        <= 1'b0;
          mem_rready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_wb_ready      = wb_ready_s;
  assign bus.o_fill_ready    = fill_ready_r;
  assign bus.o_fill_data     = fill_data_r;
  assign bus.o_fill_valid    = fill_valid_r;
  assign bus.o_mem_addr      = mem_addr_r;
  assign bus.o_mem_we        = mem_we_r;
  assign bus.o_mem_wdata     = mem_wdata_r;
  assign bus.o_mem_req_valid = mem_req_valid_r;
  assign bus.o_mem_rready    = mem_rready_r;
endmodule
